id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and execute-operand front end; the stage directly upstream of the ALU.
- Captures decoded instruction fields and control signals each cycle.
- Resolves EX/MEM and MEM/WB forwarding, then drives the ALU op_a/op_b/alu_ctrl inputs.
- Detects load-use hazards and inserts bubbles; handles pipeline stall and flush.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register-address width

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a valid instruction
id_pc  in  XLEN  instruction PC
id_rs1_addr  in  RA_W  source register 1 index
id_rs2_addr  in  RA_W  source register 2 index
id_rd_addr  in  RA_W  destination register index
id_rs1_data  in  XLEN  register-file read data 1
id_rs2_data  in  XLEN  register-file read data 2
id_imm  in  XLEN  sign-extended immediate
id_alu_ctrl  in  4  ALU opcode (ADD=0 … SRA=8)
id_alu_src_imm  in  1  1: op_b takes immediate
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  load
id_mem_write  in  1  store
stall  in  1  global freeze (downstream back-pressure)
flush  in  1  kill the instruction entering EX (branch taken)
mem_rd_addr  in  RA_W  EX/MEM destination
mem_reg_write  in  1  EX/MEM writes rd
mem_result  in  XLEN  EX/MEM ALU result
wb_rd_addr  in  RA_W  MEM/WB destination
wb_reg_write  in  1  MEM/WB writes rd
wb_result  in  XLEN  MEM/WB writeback value
ex_valid  out  1  EX slot valid
ex_pc  out  XLEN  registered PC
ex_op_a  out  XLEN  ALU operand A (forwarded)
ex_op_b  out  XLEN  ALU operand B (forwarded or immediate)
ex_alu_ctrl  out  4  ALU opcode
ex_store_data  out  XLEN  forwarded rs2 value, used for stores
ex_rd_addr  out  RA_W  destination
ex_reg_write  out  1  qualified by ex_valid
ex_mem_read  out  1  qualified by ex_valid
ex_mem_write  out  1  qualified by ex_valid
load_use_stall  out  1  upstream must hold PC/IF/ID this cycle

Behaviour:
- Reset (async, rst_n=0): every EX register clears to 0, giving ex_valid=0, all controls 0, ex_alu_ctrl=0 and zero data. Outputs are 0 while reset is held. Reset mid-instruction discards it.
- Register update priority at each rising clk edge: flush > stall > load-use bubble > load.
  - flush=1: load a bubble (valid and controls = 0), even if stall=1.
  - stall=1 (no flush): hold all registers.
  - load_use_stall=1: load a bubble.
  - otherwise: capture all id_* fields; ex_valid <= id_valid.
- Latency: an ID instruction appears in EX one cycle after capture.
- When id_valid=0, control bits are captured as 0.
- load_use_stall (combinational) = id_valid & ex_valid & ex_mem_read & ex_rd_addr≠0 & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr).
  - Asserted regardless of stall.
  - Forced 0 while flush=1.
- Forwarding (combinational, on registered rs addresses), evaluated per source, rs1 and rs2:
  - if mem_reg_write & mem_rd_addr≠0 & match → mem_result;
  - else if wb_reg_write & wb_rd_addr≠0 & match → wb_result;
  - else registered register-file data.
  - MEM has priority over WB. Register 0 never forwards.
- ex_op_a = forwarded rs1.
- ex_op_b = registered imm if alu_src_imm, else forwarded rs2.
- ex_store_data = forwarded rs2, always.
- No arithmetic in this block; widths pass through unchanged.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with a valid instruction in EX → ex_valid, ex_reg_write, ex_mem_read and ex_op_a go 0 immediately, without waiting for a clock edge.
- Basic load: id_valid=1, rs1_data=5, imm=7, alu_src_imm=1, alu_ctrl=0 → next cycle ex_op_a=5, ex_op_b=7, ex_alu_ctrl=0, ex_valid=1.
- Forward priority: EX rs1=3, mem_rd=3/mem_result=0xAAAA, wb_rd=3/wb_result=0xBBBB, both write-enables=1 → ex_op_a=0xAAAA. Drop mem_reg_write → 0xBBBB. Repeat with rs1=0 → register-file data, no forwarding.
- Load-use: EX holds load to x4; ID instruction reads rs2=x4 → load_use_stall=1. Next cycle ex_valid=0 and controls 0; the following cycle the held ID instruction enters EX with operand from wb_result.
- Stall vs flush: stall=1 for 3 cycles → EX outputs unchanged. stall=1 and flush=1 together → bubble loaded (ex_valid=0).
- Store data: store with alu_src_imm=1 and rs2 forwarded from mem_result=0x1234 → ex_op_b=imm, ex_store_data=0x1234.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus the operand front end for the ALU.
// It captures decoded fields and resolves EX/MEM and MEM/WB forwarding.
// It also raises the load-use interlock and loads bubbles on flush or
// when that interlock fires.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_alu_ctrl,
  input  logic            id_alu_src_imm,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            stall,
  input  logic            flush,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_op_a,
  output logic [XLEN-1:0] ex_op_b,
  output logic [3:0]      ex_alu_ctrl,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            load_use_stall
);

  logic [RA_W-1:0] rs1_addr_p1, rs2_addr_p1;
  logic [XLEN-1:0] rs1_data_p1, rs2_data_p1, imm_p1;
  logic            alu_src_imm_p1, reg_write_p1, mem_read_p1, mem_write_p1;
  logic            bubble;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  // Forward-select for one source operand: MEM beats WB, and x0 never forwards.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RA_W-1:0] rs,
    input logic [XLEN-1:0] rf_data,
    input logic            m_we,
    input logic [RA_W-1:0] m_rd,
    input logic [XLEN-1:0] m_val,
    input logic            w_we,
    input logic [RA_W-1:0] w_rd,
    input logic [XLEN-1:0] w_val
  );
    if (m_we && (m_rd != '0) && (m_rd == rs))
      return m_val;
    else if (w_we && (w_rd != '0) && (w_rd == rs))
      return w_val;
    else
      return rf_data;
  endfunction

  // Interlock: a load in EX whose rd is read by the instruction in ID.
  // A flush kills the ID instruction, so it cannot cause a stall.
  always_comb begin
    load_use_stall = id_valid && ex_valid && mem_read_p1 && (ex_rd_addr != '0) &&
                     ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr)) &&
                     !flush;
    bubble = flush || (!stall && load_use_stall);
  end

  // ---- ID -> EX register boundary ----
  // Priority: flush > stall > load-use bubble > normal capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bubble) begin
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      rs1_addr_p1    <= '0;
      rs2_addr_p1    <= '0;
      ex_rd_addr     <= '0;
      rs1_data_p1    <= '0;
      rs2_data_p1    <= '0;
      imm_p1         <= '0;
      ex_alu_ctrl    <= '0;
      alu_src_imm_p1 <= 1'b0;
      reg_write_p1   <= 1'b0;
      mem_read_p1    <= 1'b0;
      mem_write_p1   <= 1'b0;
    end else if (!stall) begin
      ex_valid       <= id_valid;
      ex_pc          <= id_pc;
      rs1_addr_p1    <= id_rs1_addr;
      rs2_addr_p1    <= id_rs2_addr;
      ex_rd_addr     <= id_rd_addr;
      rs1_data_p1    <= id_rs1_data;
      rs2_data_p1    <= id_rs2_data;
      imm_p1         <= id_imm;
      ex_alu_ctrl    <= id_alu_ctrl;
      alu_src_imm_p1 <= id_alu_src_imm;
      reg_write_p1   <= id_reg_write & id_valid;
      mem_read_p1    <= id_mem_read & id_valid;
      mem_write_p1   <= id_mem_write & id_valid;
    end
  end

  // ---- EX operand selection ----
  // Forwarded operands, immediate mux and valid-qualified controls.
  always_comb begin
    rs1_fwd = fwd_sel(rs1_addr_p1, rs1_data_p1, mem_reg_write, mem_rd_addr, mem_result,
                      wb_reg_write, wb_rd_addr, wb_result);
    rs2_fwd = fwd_sel(rs2_addr_p1, rs2_data_p1, mem_reg_write, mem_rd_addr, mem_result,
                      wb_reg_write, wb_rd_addr, wb_result);
    ex_op_a       = rs1_fwd;
    ex_op_b       = alu_src_imm_p1 ? imm_p1 : rs2_fwd;
    ex_store_data = rs2_fwd;
    ex_reg_write  = reg_write_p1 & ex_valid;
    ex_mem_read   = mem_read_p1 & ex_valid;
    ex_mem_write  = mem_write_p1 & ex_valid;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios plus randomized traffic
// compared against a slot-level reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write;
  logic        stall, flush;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;
  logic [31:0] ex_pc, ex_op_a, ex_op_b, ex_store_data;
  logic [3:0]  ex_alu_ctrl;
  logic [4:0]  ex_rd_addr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_ctrl(id_alu_ctrl), .id_alu_src_imm(id_alu_src_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .load_use_stall(load_use_stall)
  );

  // Reference model: the instruction currently sitting in the EX slot.
  typedef struct packed {
    logic        v;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  ctrl;
    logic        si, rw, mr, mw;
  } slot_t;

  slot_t slot;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return rf;
    if (mem_reg_write && mem_rd_addr == a) return mem_result;
    if (wb_reg_write && wb_rd_addr == a) return wb_result;
    return rf;
  endfunction

  function automatic logic ref_hazard();
    if (flush || !id_valid || !slot.v || !slot.mr || slot.rd == 5'd0) return 1'b0;
    return (slot.rd == id_rs1_addr) || (slot.rd == id_rs2_addr);
  endfunction

  task automatic idle();
    id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_ctrl = 0;
    id_alu_src_imm = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    stall = 0; flush = 0;
    mem_rd_addr = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd_addr = 0; wb_reg_write = 0; wb_result = 0;
  endtask

  // Compare against the model mid-cycle, advance the model, then cross the edge.
  task automatic cycle();
    logic [31:0] b;
    #2;
    chk("valid", ex_valid, slot.v);
    chk("reg_write", ex_reg_write, slot.v & slot.rw);
    chk("mem_read", ex_mem_read, slot.v & slot.mr);
    chk("mem_write", ex_mem_write, slot.v & slot.mw);
    chk("load_use", load_use_stall, ref_hazard());
    if (slot.v) begin
      b = ref_fwd(slot.rs2, slot.d2);
      chk("pc", ex_pc, slot.pc);
      chk("op_a", ex_op_a, ref_fwd(slot.rs1, slot.d1));
      chk("op_b", ex_op_b, slot.si ? slot.imm : b);
      chk("store_data", ex_store_data, b);
      chk("alu_ctrl", ex_alu_ctrl, slot.ctrl);
      chk("rd", ex_rd_addr, slot.rd);
    end
    if (flush) slot = '0;
    else if (stall) slot = slot;
    else if (ref_hazard()) slot = '0;
    else begin
      slot.v = id_valid; slot.pc = id_pc; slot.d1 = id_rs1_data; slot.d2 = id_rs2_data;
      slot.imm = id_imm; slot.rs1 = id_rs1_addr; slot.rs2 = id_rs2_addr;
      slot.rd = id_rd_addr; slot.ctrl = id_alu_ctrl; slot.si = id_alu_src_imm;
      slot.rw = id_reg_write & id_valid; slot.mr = id_mem_read & id_valid;
      slot.mw = id_mem_write & id_valid;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    slot = '0;
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", ex_valid, 0);
    chk("rst_reg_write", ex_reg_write, 0);
    chk("rst_alu_ctrl", ex_alu_ctrl, 0);
    chk("rst_op_a", ex_op_a, 0);
    rst_n = 1;

    // Basic register-immediate capture
    id_valid = 1; id_pc = 32'h100; id_rs1_addr = 1; id_rs1_data = 5; id_imm = 7;
    id_alu_src_imm = 1; id_alu_ctrl = 0; id_reg_write = 1; id_rd_addr = 2;
    cycle();
    idle(); #1;
    chk("basic_op_a", ex_op_a, 5);
    chk("basic_op_b", ex_op_b, 7);
    chk("basic_ctrl", ex_alu_ctrl, 0);
    chk("basic_valid", ex_valid, 1);
    cycle();

    // Forwarding priority on rs1=3, then rs1=0
    id_valid = 1; id_rs1_addr = 3; id_rs1_data = 32'h11; id_reg_write = 1; id_rd_addr = 8;
    cycle();
    idle();
    mem_rd_addr = 3; mem_reg_write = 1; mem_result = 32'hAAAA;
    wb_rd_addr = 3; wb_reg_write = 1; wb_result = 32'hBBBB;
    #1 chk("fwd_mem_first", ex_op_a, 32'hAAAA);
    mem_reg_write = 0;
    #1 chk("fwd_wb", ex_op_a, 32'hBBBB);
    cycle();
    idle();
    id_valid = 1; id_rs1_addr = 0; id_rs1_data = 32'h77; id_rd_addr = 9;
    cycle();
    idle();
    mem_rd_addr = 0; mem_reg_write = 1; mem_result = 32'hAAAA;
    wb_rd_addr = 0; wb_reg_write = 1; wb_result = 32'hBBBB;
    #1 chk("fwd_x0", ex_op_a, 32'h77);
    cycle();

    // Load-use interlock
    idle();
    id_valid = 1; id_rd_addr = 4; id_mem_read = 1; id_reg_write = 1;
    cycle();
    idle();
    id_valid = 1; id_rs1_addr = 1; id_rs1_data = 3; id_rs2_addr = 4; id_rs2_data = 32'h99;
    id_rd_addr = 5; id_reg_write = 1;
    #1 chk("lu_stall", load_use_stall, 1);
    cycle();
    wb_rd_addr = 4; wb_reg_write = 1; wb_result = 32'h55;
    #1;
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_rw", ex_reg_write, 0);
    chk("lu_bubble_mr", ex_mem_read, 0);
    chk("lu_released", load_use_stall, 0);
    cycle();
    #1;
    chk("lu_enter_valid", ex_valid, 1);
    chk("lu_op_a", ex_op_a, 3);
    chk("lu_op_b_wb", ex_op_b, 32'h55);
    cycle();

    // Stall holds; stall+flush bubbles
    idle();
    id_valid = 1; id_pc = 32'h200; id_rs1_addr = 2; id_rs1_data = 32'h42; id_reg_write = 1;
    id_rd_addr = 6;
    cycle();
    idle();
    id_valid = 1; id_pc = 32'h300; id_rs1_data = 32'h13; stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_pc", ex_pc, 32'h200);
      chk("stall_op_a", ex_op_a, 32'h42);
      chk("stall_valid", ex_valid, 1);
      cycle();
    end
    flush = 1;
    cycle();
    #1;
    chk("flush_valid", ex_valid, 0);
    chk("flush_rw", ex_reg_write, 0);

    // Store data forwarded while op_b takes the immediate
    idle();
    id_valid = 1; id_mem_write = 1; id_alu_src_imm = 1; id_imm = 32'h10;
    id_rs2_addr = 6; id_rs2_data = 32'h1;
    cycle();
    idle();
    mem_rd_addr = 6; mem_reg_write = 1; mem_result = 32'h1234;
    #1;
    chk("st_op_b", ex_op_b, 32'h10);
    chk("st_data", ex_store_data, 32'h1234);
    chk("st_mw", ex_mem_write, 1);
    cycle();

    // Asynchronous reset mid-cycle discards the EX instruction
    idle();
    id_valid = 1; id_reg_write = 1; id_mem_read = 1; id_rd_addr = 7;
    id_rs1_addr = 2; id_rs1_data = 32'h5A;
    cycle();
    idle();
    #2;
    chk("pre_rst_valid", ex_valid, 1);
    rst_n = 0;
    #1;
    chk("arst_valid", ex_valid, 0);
    chk("arst_rw", ex_reg_write, 0);
    chk("arst_mr", ex_mem_read, 0);
    chk("arst_op_a", ex_op_a, 0);
    slot = '0;
    @(posedge clk);
    #1 rst_n = 1;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      id_valid = ($urandom_range(0, 9) < 8);
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1_addr = 5'($urandom_range(0, 3)); id_rs2_addr = 5'($urandom_range(0, 3));
      id_rd_addr = 5'($urandom_range(0, 3));
      id_alu_ctrl = 4'($urandom_range(0, 8));
      id_alu_src_imm = 1'($urandom); id_reg_write = 1'($urandom);
      id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = ($urandom_range(0, 3) == 0);
      stall = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 9) == 0);
      mem_rd_addr = 5'($urandom_range(0, 3)); mem_reg_write = 1'($urandom);
      mem_result = $urandom;
      wb_rd_addr = 5'($urandom_range(0, 3)); wb_reg_write = 1'($urandom);
      wb_result = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
